// File: rtl/tia_line_reader.sv
// Dual-bank scanline buffer between the TIA pixel stream and VGA scan-out.
// The writer fills one bank while the reader displays the other. Banks swap
// at even VGA line starts, so each TIA line is shown on two VGA lines.
module tia_line_reader #(
  parameter int LINE_PIXELS = 160,
  parameter int COLOR_W     = 7,
  parameter int H_SCALE     = 4,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [7:0]         wr_xpos,
  input  logic [COLOR_W-1:0] wr_color,
  input  logic               wr_eol,
  input  logic [9:0]         rd_x,
  input  logic [9:0]         rd_y,
  input  logic               rd_active,
  output logic [COLOR_W-1:0] rd_color,
  output logic [CNT_W-1:0]   underrun_cnt,
  output logic [CNT_W-1:0]   overrun_cnt
);

  localparam int          IDX_W = $clog2(LINE_PIXELS);
  localparam int          SH    = $clog2(H_SCALE);
  localparam logic [7:0]  LP_W  = 8'(LINE_PIXELS);
  localparam logic [9:0]  LP_R  = 10'(LINE_PIXELS);

  // Two line banks; contents are not reset.
  logic [COLOR_W-1:0] mem [0:1][0:LINE_PIXELS-1];

  logic               wr_bank_q, wr_bank_d;
  logic               rd_bank_q, rd_bank_d;
  logic               ready_bank_q, ready_bank_d;
  logic               line_ready_q, line_ready_d;
  logic [CNT_W-1:0]   underrun_cnt_q, underrun_cnt_d;
  logic [CNT_W-1:0]   overrun_cnt_q, overrun_cnt_d;
  logic [COLOR_W-1:0] rd_color_q, rd_color_d;

  logic               line_start;
  logic               wr_hit;
  logic [9:0]         rd_idx_full;
  logic [IDX_W-1:0]   rd_idx;
  logic [IDX_W-1:0]   wr_idx;

  assign line_start  = (rd_x == 10'd0) && !rd_y[0];
  assign wr_hit      = wr_en && (wr_xpos < LP_W);
  assign wr_idx      = wr_xpos[IDX_W-1:0];
  assign rd_idx_full = rd_x >> SH;
  assign rd_idx      = rd_idx_full[IDX_W-1:0];

  // Pixel capture into the bank currently owned by the writer (pre-swap bank).
  always_ff @(posedge clk) begin
    if (wr_hit) mem[wr_bank_q][wr_idx] <= wr_color;
  end

  // Bank handoff, status counters and the registered read pixel.
  always_comb begin
    wr_bank_d      = wr_bank_q;
    rd_bank_d      = rd_bank_q;
    ready_bank_d   = ready_bank_q;
    line_ready_d   = line_ready_q;
    underrun_cnt_d = underrun_cnt_q;
    overrun_cnt_d  = overrun_cnt_q;

    if (wr_eol) begin
      ready_bank_d = wr_bank_q;
      line_ready_d = 1'b1;
      if (line_start)
        wr_bank_d = rd_bank_q;          // reader grabs this line, writer takes the released bank
      else if (!line_ready_q)
        wr_bank_d = ~wr_bank_q;
      else if (overrun_cnt_q != '1)
        overrun_cnt_d = overrun_cnt_q + CNT_W'(1);  // newest line overwrites in place
    end

    if (line_start) begin
      if (line_ready_q || wr_eol) begin
        rd_bank_d    = wr_eol ? wr_bank_q : ready_bank_q;
        line_ready_d = 1'b0;
      end else if (underrun_cnt_q != '1) begin
        underrun_cnt_d = underrun_cnt_q + CNT_W'(1);
      end
    end

    // Read from the bank that is displayed after any swap this cycle.
    rd_color_d = '0;
    if (rd_active && (rd_idx_full < LP_R))
      rd_color_d = mem[rd_bank_d][rd_idx];
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank_q      <= 1'b0;
      rd_bank_q      <= 1'b1;
      ready_bank_q   <= 1'b0;
      line_ready_q   <= 1'b0;
      underrun_cnt_q <= '0;
      overrun_cnt_q  <= '0;
      rd_color_q     <= '0;
    end else begin
      wr_bank_q      <= wr_bank_d;
      rd_bank_q      <= rd_bank_d;
      ready_bank_q   <= ready_bank_d;
      line_ready_q   <= line_ready_d;
      underrun_cnt_q <= underrun_cnt_d;
      overrun_cnt_q  <= overrun_cnt_d;
      rd_color_q     <= rd_color_d;
    end
  end

  assign rd_color     = rd_color_q;
  assign underrun_cnt = underrun_cnt_q;
  assign overrun_cnt  = overrun_cnt_q;

endmodule
